// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and operand helper for the HI/LO sequencer
package muldiv_pkg;
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;
    localparam int DIV_ITERS = 32;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_SIGN} state_t;
    function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
        return (s && x[31]) ? 32'(-x) : x;
    endfunction
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-division iteration on {rem,quo}
module muldiv_div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] dvs,
    output logic [31:0] rem_n,
    output logic [31:0] quo_n
);
    logic [32:0] sh, diff;
    // shift next dividend bit into the remainder, keep the trial difference if non-negative
    always_comb begin
        sh    = {rem, quo[31]};
        diff  = sh - {1'b0, dvs};
        rem_n = diff[32] ? sh[31:0] : diff[31:0];
        quo_n = {quo[30:0], ~diff[32]};
    end
endmodule

// File: rtl/muldiv_ctrl32.sv
// muldiv_ctrl32: multi-cycle mult/div sequencer owning HI/LO; MULDIV_DIV0_TRAP_EN enables the divide-by-zero trap
module muldiv_ctrl32
    import muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] Ainput,
    input  logic [31:0] Binput,
    input  logic        flush,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
`ifdef MULDIV_DIV0_TRAP_EN
    ,
    output logic        div0
`endif
);
    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] a, b, rem, rem_n, quo_n;
    logic        sgn, neg_q, neg_r, bz;
    logic [63:0] prod;
    logic        is_div, is_signed;

    assign is_div    = op == MD_DIV || op == MD_DIVU;
    assign is_signed = op == MD_MULT || op == MD_DIV;
    assign prod      = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};

    muldiv_div_step u_step (.rem(rem), .quo(a), .dvs(b), .rem_n(rem_n), .quo_n(quo_n));

    // sequencer: accept ops and moves in IDLE, iterate, write HI/LO on completion
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            rem   <= '0;
            sgn   <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            bz    <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
            div0  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
            div0 <= 1'b0;
`endif
            if (state != S_IDLE && flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            busy  <= 1'b1;
                            cnt   <= '0;
                            rem   <= '0;
                            sgn   <= is_signed;
                            bz    <= Binput == '0;
                            neg_q <= is_signed & (Ainput[31] ^ Binput[31]);
                            neg_r <= is_signed & Ainput[31];
                            a     <= is_div ? mag(Ainput, is_signed) : Ainput;
                            b     <= is_div ? mag(Binput, is_signed) : Binput;
                            state <= is_div ? S_DIV : S_MUL;
                        end else begin
                            if (mthi) hi <= wdata;
                            if (mtlo) lo <= wdata;
                        end
                    end
                    S_MUL: begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'(MUL_LATENCY - 1)) begin
                            {hi, lo} <= prod;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                    S_DIV: begin
`ifdef MULDIV_DIV0_TRAP_EN
                        if (bz) begin
                            div0  <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else
`endif
                        begin
                            a   <= quo_n;
                            rem <= rem_n;
                            cnt <= cnt + 5'd1;
                            if (cnt == 5'(DIV_ITERS - 1)) state <= S_SIGN;
                        end
                    end
                    S_SIGN: begin
                        lo    <= (neg_q && !bz) ? 32'(-a) : a;
                        hi    <= neg_r ? 32'(-rem) : rem;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl32.sv
// tb_muldiv_ctrl32: randomized self-checking bench for muldiv_ctrl32 against an arithmetic reference model
module tb_muldiv_ctrl32;
    localparam int LAT = 4;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] Ainput = '0, Binput = '0, wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div0;
    int errors = 0, checks = 0;

    muldiv_ctrl32 #(.MUL_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .Ainput(Ainput), .Binput(Binput),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi(hi), .lo(lo),
        .busy(busy), .done(done)
`ifdef MULDIV_DIV0_TRAP_EN
        , .div0(div0)
`endif
    );
`ifndef MULDIV_DIV0_TRAP_EN
    assign div0 = 1'b0;
`endif

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ix = $signed(x);
        iy = $signed(y);
        if (o == 2'b00) return 64'(sx * sy);
        if (o == 2'b01) return {32'd0, x} * {32'd0, y};
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (o == 2'b11) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(ix % iy), 32'(ix / iy)};
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [31:0] h, output logic [31:0] l, output logic d0);
        lat = 0; h = 'x; l = 'x; d0 = 1'b0;
        @(negedge clock);
        start = 1'b1; op = o; Ainput = x; Binput = y;
        @(posedge clock);
        #1;
        start = 1'b0; op = 2'($urandom); Ainput = $urandom; Binput = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = k; h = hi; l = lo; d0 = div0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clock);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_5A5A;
        @(posedge clock);
        #1;
        mthi = 1'b0; mtlo = 1'b0;
        @(negedge clock);
        start = 1'b1; op = 2'b10; Ainput = 32'd1000; Binput = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", hi, lo); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_busy_done got=%b/%b exp=0/0", busy, done); end
        @(negedge clock);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL midreset_no_done got=%0d pulses exp=0", n); end
    endtask

    task automatic test_mult();
        logic [31:0] x, y, h, l;
        logic [1:0] o;
        logic [63:0] e;
        logic d0;
        int lat;
        for (int i = 0; i < 14; i++) begin
            o = (i < 4) ? 2'(i % 2) : 2'($urandom_range(0, 1));
            x = (i < 2) ? 32'hFFFF_FFFE : (i < 4) ? 32'h8000_0000 : $urandom;
            y = (i < 2) ? 32'd3 : (i == 2) ? 32'h8000_0000 : (i == 3) ? 32'hFFFF_FFFF : $urandom;
            e = ref_model(o, x, y);
            do_op(o, x, y, lat, h, l, d0);
            checks++; if (lat != LAT) begin errors++; $display("FAIL mul_latency op=%0d got=%0d exp=%0d", o, lat, LAT); end
            checks++; if (h !== e[63:32]) begin errors++; $display("FAIL mul_hi op=%0d a=%h b=%h got=%h exp=%h", o, x, y, h, e[63:32]); end
            checks++; if (l !== e[31:0]) begin errors++; $display("FAIL mul_lo op=%0d a=%h b=%h got=%h exp=%h", o, x, y, l, e[31:0]); end
        end
    endtask

    task automatic test_div();
        logic [31:0] x, y, h, l;
        logic [1:0] o;
        logic [63:0] e;
        logic d0;
        int lat;
        for (int i = 0; i < 14; i++) begin
            o = (i < 4) ? ((i % 2 == 0) ? 2'b10 : 2'b11) : 2'($urandom_range(2, 3));
            x = (i == 0) ? 32'hFFFF_FFF9 : (i == 1) ? 32'd7 : (i == 2) ? 32'h8000_0000 : (i == 3) ? 32'hFFFF_FFFF : $urandom;
            y = (i < 2) ? 32'd2 : (i == 2) ? 32'hFFFF_FFFF : (i == 3) ? 32'd1 : (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
            if (y == 0) y = 32'd1;
            if (i >= 4 && i % 3 == 0) y = -y;
            e = ref_model(o, x, y);
            do_op(o, x, y, lat, h, l, d0);
            checks++; if (lat != 33) begin errors++; $display("FAIL div_latency op=%0d got=%0d exp=33", o, lat); end
            checks++; if (l !== e[31:0]) begin errors++; $display("FAIL div_lo op=%0d a=%h b=%h got=%h exp=%h", o, x, y, l, e[31:0]); end
            checks++; if (h !== e[63:32]) begin errors++; $display("FAIL div_hi op=%0d a=%h b=%h got=%h exp=%h", o, x, y, h, e[63:32]); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat = 0;
        logic [31:0] h0, w;
        @(negedge clock);
        start = 1'b1; op = 2'b11; Ainput = 32'd100; Binput = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        h0 = hi;
        repeat (4) @(posedge clock);
        @(negedge clock);
        start = 1'b1; op = 2'b00; Ainput = 32'd3; Binput = 32'd3; mthi = 1'b1; wdata = 32'h1234;
        @(posedge clock);
        #1;
        start = 1'b0; mthi = 1'b0;
        checks++; if (hi !== h0) begin errors++; $display("FAIL busy_mthi_ignored got=%h exp=%h", hi, h0); end
        for (int k = 6; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (done) begin lat = k; break; end
        end
        checks++; if (lat != 33) begin errors++; $display("FAIL busy_start_latency got=%0d exp=33", lat); end
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL busy_start_result got=%h/%h exp=00000002/0000000e", hi, lo); end
        @(posedge clock);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse_width got done=%b busy=%b exp=0/0", done, busy); end
        @(negedge clock);
        mthi = 1'b1; wdata = 32'h1234;
        @(posedge clock);
        #1;
        mthi = 1'b0;
        checks++; if (hi !== 32'h1234 || lo !== 32'd14) begin errors++; $display("FAIL idle_mthi got=%h/%h exp=00001234/0000000e", hi, lo); end
        w = $urandom;
        @(negedge clock);
        mthi = 1'b1; mtlo = 1'b1; wdata = w;
        @(posedge clock);
        #1;
        mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== w || lo !== w) begin errors++; $display("FAIL idle_mthi_mtlo got=%h/%h exp=%h/%h", hi, lo, w, w); end
        @(negedge clock);
        start = 1'b1; op = 2'b01; Ainput = 32'd5; Binput = 32'd6; mthi = 1'b1; wdata = ~w;
        @(posedge clock);
        #1;
        start = 1'b0; mthi = 1'b0;
        checks++; if (hi !== w || busy !== 1'b1) begin errors++; $display("FAIL start_with_mthi got hi=%h busy=%b exp hi=%h busy=1", hi, busy, w); end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            if (done) begin lat = k; break; end
        end
        checks++; if (lat != LAT || hi !== 32'd0 || lo !== 32'd30) begin errors++; $display("FAIL start_with_mthi_result got lat=%0d %h/%h exp lat=%0d 00000000/0000001e", lat, hi, lo, LAT); end
    endtask

    task automatic test_flush();
        logic [31:0] hv, lv;
        int n, fa;
        for (int s = 0; s < 3; s++) begin
            fa = (s == 0) ? 20 : (s == 1) ? 33 : LAT;
            hv = $urandom; lv = $urandom;
            @(negedge clock);
            mthi = 1'b1; wdata = hv;
            @(posedge clock);
            #1;
            mthi = 1'b0;
            @(negedge clock);
            mtlo = 1'b1; wdata = lv;
            @(posedge clock);
            #1;
            mtlo = 1'b0;
            @(negedge clock);
            start = 1'b1; op = (s == 2) ? 2'b00 : 2'($urandom_range(2, 3)); Ainput = $urandom; Binput = $urandom_range(1, 5000);
            @(posedge clock);
            #1;
            start = 1'b0;
            repeat (fa - 1) @(posedge clock);
            @(negedge clock);
            flush = 1'b1;
            @(posedge clock);
            #1;
            flush = 1'b0;
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush%0d_state got busy=%b done=%b exp=0/0", fa, busy, done); end
            checks++; if (hi !== hv || lo !== lv) begin errors++; $display("FAIL flush%0d_hilo got=%h/%h exp=%h/%h", fa, hi, lo, hv, lv); end
            n = 0;
            repeat (40) begin
                @(posedge clock);
                #1;
                if (done) n++;
            end
            checks++; if (n != 0 || hi !== hv || lo !== lv) begin errors++; $display("FAIL flush%0d_after got pulses=%0d %h/%h exp=0 %h/%h", fa, n, hi, lo, hv, lv); end
        end
    endtask

    task automatic test_div0();
        logic [31:0] x, h, l, h0, l0;
        logic [1:0] o;
        logic d0;
        int lat;
        for (int i = 0; i < 2; i++) begin
            o = (i == 0) ? 2'b11 : 2'b10;
            x = (i == 0) ? $urandom : 32'h8000_0005;
            h0 = hi; l0 = lo;
            do_op(o, x, 32'd0, lat, h, l, d0);
`ifdef MULDIV_DIV0_TRAP_EN
            checks++; if (lat != 1 || d0 !== 1'b1) begin errors++; $display("FAIL div0_trap op=%0d got lat=%0d div0=%b exp=1/1", o, lat, d0); end
            checks++; if (h !== h0 || l !== l0) begin errors++; $display("FAIL div0_trap_hilo got=%h/%h exp=%h/%h", h, l, h0, l0); end
`else
            checks++; if (lat != 33) begin errors++; $display("FAIL div0_latency op=%0d got=%0d exp=33", o, lat); end
            checks++; if (l !== 32'hFFFF_FFFF || h !== x) begin errors++; $display("FAIL div0_result op=%0d got=%h/%h exp=%h/ffffffff (prev %h/%h)", o, h, l, x, h0, l0); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_busy_ignore();
        test_flush();
        test_div0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
